// File: rtl/bpf_zc_period_meter.sv
// Zero-crossing period meter behind the 325 kHz bandpass filter.
// It qualifies rising crossings with hysteresis and sums 2^AVG_LOG2 periods for the frequency controller.
module bpf_zc_period_meter #(
   parameter int CNT_W      = 12,
   parameter int HYST       = 64,
   parameter int MIN_PERIOD = 8,
   parameter int MAX_PERIOD = 1023,
   parameter int AVG_LOG2   = 3
) (
   input  logic                      clk325kHz,
   input  logic                      rst,
   input  logic signed [13:0]        bpf_out,
   input  logic signed [13:0]        bpf_out_delay,
   output logic                      crossing,
   output logic [CNT_W+AVG_LOG2-1:0] period_sum,
   output logic                      period_valid,
   output logic                      locked,
   output logic                      lost
);

   localparam int SUM_W = CNT_W + AVG_LOG2;
   localparam logic signed [13:0] ARM_LEVEL = 14'(-HYST);
   localparam logic [CNT_W-1:0]    MIN_CNT   = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0]    MAX_CNT   = CNT_W'(MAX_PERIOD);
   localparam logic [AVG_LOG2-1:0] N_LAST    = '1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [SUM_W-1:0]    acc;
   logic [AVG_LOG2-1:0] n;
   logic                armed;
   logic                candidate;
   logic                accept;
   logic [SUM_W-1:0]    sum_next;

   // armed is the registered value, so the arming sample can never qualify itself
   assign candidate = armed && (bpf_out_delay < 14'sd0) && (bpf_out >= 14'sd0);
   assign accept    = candidate && (cnt >= MIN_CNT);
   assign sum_next  = acc + SUM_W'(cnt);

   always_ff @(posedge clk325kHz) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         acc          <= '0;
         n            <= '0;
         armed        <= 1'b0;
         period_sum   <= '0;
         crossing     <= 1'b0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         lost         <= 1'b0;
      end else begin
         crossing     <= 1'b0;
         period_valid <= 1'b0;
         lost         <= 1'b0;
         if (bpf_out <= ARM_LEVEL)
            armed <= 1'b1;

         case (state)
            IDLE: begin
               cnt <= '0;
               if (candidate) begin
                  state    <= RUN;
                  cnt      <= CNT_W'(1);
                  acc      <= '0;
                  n        <= '0;
                  armed    <= 1'b0;
                  crossing <= 1'b1;
               end
            end

            RUN: begin
               // An accepted crossing wins over a timeout landing in the same cycle
               if (accept) begin
                  crossing <= 1'b1;
                  armed    <= 1'b0;
                  cnt      <= CNT_W'(1);
                  if (n == N_LAST) begin
                     period_sum   <= sum_next;
                     period_valid <= 1'b1;
                     locked       <= 1'b1;
                     acc          <= '0;
                     n            <= '0;
                  end else begin
                     acc <= sum_next;
                     n   <= n + AVG_LOG2'(1);
                  end
               end else if (cnt == MAX_CNT) begin
                  lost   <= 1'b1;
                  locked <= 1'b0;
                  state  <= IDLE;
                  cnt    <= '0;
                  acc    <= '0;
                  n      <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bpf_zc_period_meter.sv
// Directed bench for bpf_zc_period_meter: sine lock, 15/17 spacing, noise, loss, glitch reject, mid-run reset.
module tb_bpf_zc_period_meter;

   logic               clk325kHz;
   logic               rst;
   logic signed [13:0] bpf_out;
   logic signed [13:0] bpf_out_delay;
   logic               crossing;
   logic [14:0]        period_sum;
   logic               period_valid;
   logic               locked;
   logic               lost;

   int testsRun = 0;
   int testsFailed = 0;
   logic signed [13:0] prevSample;

   // Sine with period 16 and amplitude 4000; index 0 is the rising zero
   int sineTab[16] = '{0, 1531, 2828, 3696, 4000, 3696, 2828, 1531,
                       0, -1531, -2828, -3696, -4000, -3696, -2828, -1531};
   int noiseTab[8] = '{30, -30, -20, 25, -30, 10, 30, -25};
   int dipTab[5]   = '{40, -40, 40, -70, 40};

   bpf_zc_period_meter dut (
      .clk325kHz    (clk325kHz),
      .rst          (rst),
      .bpf_out      (bpf_out),
      .bpf_out_delay(bpf_out_delay),
      .crossing     (crossing),
      .period_sum   (period_sum),
      .period_valid (period_valid),
      .locked       (locked),
      .lost         (lost)
   );

   initial clk325kHz = 1'b0;
   always #5 clk325kHz = ~clk325kHz;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Drives one sample pair and returns just after the edge that registers its effect
   task automatic applyStimulus(input int s);
      @(negedge clk325kHz);
      bpf_out_delay = prevSample;
      bpf_out       = 14'(s);
      prevSample    = 14'(s);
      @(posedge clk325kHz);
      #1;
   endtask

   task automatic applyReset();
      @(negedge clk325kHz);
      rst = 1'b1;
      @(posedge clk325kHz);
      #1;
      checkOutput("reset crossing", int'(crossing), 0);
      checkOutput("reset period_valid", int'(period_valid), 0);
      checkOutput("reset locked", int'(locked), 0);
      checkOutput("reset lost", int'(lost), 0);
      checkOutput("reset period_sum", int'(period_sum), 0);
      rst = 1'b0;
      prevSample = '0;
   endtask

   // Sine from phase 0 after reset: crossings at k=16,32,...; sums at k=144,272,...
   task automatic runSine(input int kLast, input bit inject);
      int s;
      bit expCross, expValid;
      for (int k = 0; k <= kLast; k++) begin
         s = sineTab[k % 16];
         if (inject && (k == 145 || k == 146)) s = -100;
         if (inject && k == 147) s = 100;
         applyStimulus(s);
         expCross = (k >= 16) && (k % 16 == 0);
         expValid = expCross && (k > 16) && ((((k - 16) / 16) % 8) == 0);
         checkOutput($sformatf("sine crossing k=%0d", k), int'(crossing), int'(expCross));
         checkOutput($sformatf("sine period_valid k=%0d", k), int'(period_valid), int'(expValid));
         checkOutput($sformatf("sine locked k=%0d", k), int'(locked), int'(k >= 144));
         checkOutput($sformatf("sine lost k=%0d", k), int'(lost), 0);
         if (expValid)
            checkOutput($sformatf("sine period_sum k=%0d", k), int'(period_sum), 128);
      end
   endtask

   initial begin
      int lostAt;
      int lostCount;
      int posLen;
      rst           = 1'b1;
      bpf_out       = '0;
      bpf_out_delay = '0;
      prevSample    = '0;

      // Sine lock, then hold at zero until the timeout
      applyReset();
      runSine(272, 1'b0);
      lostAt = -1;
      lostCount = 0;
      for (int j = 1; j <= 1030; j++) begin
         applyStimulus(0);
         if (lost) begin
            lostCount++;
            if (lostAt < 0) lostAt = j;
         end
         if (j == 1022) checkOutput("hold locked before timeout", int'(locked), 1);
      end
      checkOutput("lost sample index", lostAt, 1023);
      checkOutput("lost pulse count", lostCount, 1);
      checkOutput("locked after loss", int'(locked), 0);
      checkOutput("period_sum held after loss", int'(period_sum), 128);

      // Square wave with crossing spacing alternating 15/17
      for (int b = 0; b <= 16; b++) begin
         posLen = (b % 2 == 0) ? 7 : 9;
         for (int i = 0; i < 8; i++) begin
            applyStimulus(-2000);
            checkOutput($sformatf("square neg crossing b=%0d", b), int'(crossing), 0);
         end
         for (int i = 0; i < posLen; i++) begin
            applyStimulus(2000);
            checkOutput($sformatf("square crossing b=%0d i=%0d", b, i), int'(crossing), int'(i == 0));
            if (i == 0) begin
               checkOutput($sformatf("square period_valid b=%0d", b), int'(period_valid),
                           int'(b == 8 || b == 16));
               checkOutput($sformatf("square locked b=%0d", b), int'(locked), int'(b >= 8));
               if (b == 8 || b == 16)
                  checkOutput($sformatf("square period_sum b=%0d", b), int'(period_sum), 128);
            end
         end
      end

      // Small noise never arms; a dip below -HYST does
      applyReset();
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 8; i++) begin
            applyStimulus(noiseTab[i]);
            checkOutput("noise crossing", int'(crossing), 0);
            checkOutput("noise period_valid", int'(period_valid), 0);
            checkOutput("noise locked", int'(locked), 0);
         end
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(dipTab[i]);
         checkOutput($sformatf("dip crossing i=%0d", i), int'(crossing), int'(i == 4));
      end

      // Glitch crossing at cnt=3 is rejected; run on to n=4 of the next sum
      applyReset();
      runSine(340, 1'b1);
      checkOutput("locked before mid reset", int'(locked), 1);
      checkOutput("period_sum before mid reset", int'(period_sum), 128);

      // Mid-accumulation reset: a fresh 9 crossings are needed
      applyReset();
      runSine(150, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
